branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Sits downstream of the fetch-stage branch predictor/BTB block.
- Carries each fetched instruction's prediction (hit, pred, target) through ID to EX and compares it with the outcome EX resolves.
- Drives the fetch redirect/flush and the predictor/BTB update interface (update_predictor, update_btb, actually_taken, resolved_pc, resolved_pc_target).
- Keeps branch and mispredict counters.

Parameters:
DATA_WIDTH, 32, PC/target width
CNT_WIDTH, 32, statistics counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  reset; synchronous, active-high (reset asserted when rstn=1)
if_valid  input  1  instruction fetched this cycle
if_pc  input  DATA_WIDTH  fetched PC
if_hit  input  1  BTB hit for if_pc
if_pred  input  1  predicted taken for if_pc
if_target  input  DATA_WIDTH  BTB target for if_pc
stall  input  1  pipeline hold; freezes both tracking slots
ex_is_branch  input  1  EX-slot instruction is a conditional branch
ex_is_jump  input  1  EX-slot instruction is an unconditional jump (jal/jalr)
ex_taken  input  1  resolved direction (ignored for jumps, treated as 1)
ex_target  input  DATA_WIDTH  resolved target
redirect  output  1  mispredict detected this cycle
redirect_pc  output  DATA_WIDTH  correct next fetch PC
flush  output  1  kill IF/ID younger instructions (equals redirect)
update_predictor  output  1  registered predictor update strobe
update_btb  output  1  registered BTB update strobe
actually_taken  output  1  registered resolved direction
resolved_pc  output  DATA_WIDTH  registered PC of resolved instruction
resolved_pc_target  output  DATA_WIDTH  registered resolved target
br_count  output  CNT_WIDTH  resolved branches+jumps
mispred_count  output  CNT_WIDTH  mispredicts

Behaviour:
- Slots: ID and EX. Each holds {valid, pc, hit, pred, target}.
- Reset (rstn=1 at edge):
  - both slots invalid, all fields 0.
  - update_predictor, update_btb, actually_taken = 0; resolved_pc, resolved_pc_target = 0.
  - br_count, mispred_count = 0.
  - Takes priority over every other event, including mid-resolution; no update from that cycle is emitted.
- Advance (stall=0, redirect=0):
  - EX <= ID.
  - ID <= {if_valid, if_pc, if_hit, if_pred, if_target}.
- stall=1: both slots hold; no resolution occurs; redirect = 0; update strobes = 0 next cycle.
- Resolution condition: resolve = EX.valid & (ex_is_branch | ex_is_jump) & !stall. ex_* inputs are ignored otherwise.
- Effective predicted-taken:
  - ptaken = EX.hit & (EX.pred | ex_is_jump).
  - Jumps resolve as taken.
- Actual direction and mispredict:
  - taken = ex_is_jump | ex_taken.
  - mispredict = resolve & ((ptaken != taken) | (taken & ptaken & (EX.target != ex_target))).
- Redirect outputs (combinational, same cycle):
  - redirect = flush = mispredict.
  - redirect_pc = taken ? ex_target : EX.pc + 4, with modulo 2^DATA_WIDTH wrap.
  - When redirect=0, redirect_pc = 0.
- On redirect (next edge):
  - ID and EX both invalid.
  - IF capture of that cycle is discarded.
- Update strobes (registered, 1-cycle latency after resolve):
  - update_predictor = resolve & ex_is_branch.
  - update_btb = resolve & taken & (!EX.hit | EX.target != ex_target).
  - actually_taken = taken; resolved_pc = EX.pc; resolved_pc_target = ex_target.
  - Data fields update only when resolve=1, otherwise hold. Strobes are 0 in cycles without resolve.
- Counters:
  - br_count += 1 on resolve; mispred_count += 1 on mispredict.
  - Both saturate at all-ones.
- Simultaneous ex_is_branch & ex_is_jump: treated as jump (taken=1, update_predictor=0).
- Back-to-back: a resolve every cycle is supported; a redirect removes the following two tracked instructions, so no resolve occurs for 2 cycles after it.

Test Plan:
- Reset: drive rstn=1 for 2 cycles with if_valid=1 -> all outputs 0, counters 0. Then release and feed NOP PCs 0x0,0x4,0x8 with ex_is_branch=0 -> redirect never 1.
- Correct taken prediction: fetch pc=0x100 with hit=1, pred=1, target=0x200. Two cycles later ex_is_branch=1, ex_taken=1, ex_target=0x200 -> redirect=0. Next cycle update_predictor=1, update_btb=0, actually_taken=1, resolved_pc=0x100. br_count=1, mispred_count=0.
- Predicted-taken branch actually not taken: pc=0x40 with hit=1, pred=1, target=0x80; EX ex_taken=0 -> redirect=1, redirect_pc=0x44. Next cycle ID/EX invalid, update_predictor=1, update_btb=0, mispred_count=1.
- BTB miss on jump: pc=0x10 with hit=0; EX ex_is_jump=1, ex_target=0x300 -> redirect=1, redirect_pc=0x300. Next cycle update_btb=1, update_predictor=0, resolved_pc_target=0x300.
- Stall during resolve: hold stall=1 for 3 cycles with EX holding a mispredicting branch -> redirect=0 and no strobes during stall. On the first cycle with stall=0 -> exactly one redirect and one update pulse.
- Counter saturation and wrap: CNT_WIDTH=2, 5 mispredicts -> mispred_count stays 3. Branch at pc=0xFFFFFFFC not taken, predicted taken -> redirect_pc=0x00000000.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Tracks each fetched instruction's BTB prediction through ID and EX, compares it with
// the EX outcome, and drives the fetch redirect, the predictor/BTB update and the statistics.
module branch_resolve_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic                  if_hit,
  input  logic                  if_pred,
  input  logic [DATA_WIDTH-1:0] if_target,
  input  logic                  stall,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  update_predictor,
  output logic                  update_btb,
  output logic                  actually_taken,
  output logic [DATA_WIDTH-1:0] resolved_pc,
  output logic [DATA_WIDTH-1:0] resolved_pc_target,
  output logic [CNT_WIDTH-1:0]  br_count,
  output logic [CNT_WIDTH-1:0]  mispred_count
);

  logic                  id_valid_q, id_valid_d, ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d, ex_pc_q, ex_pc_d;
  logic                  id_hit_q, id_hit_d, ex_hit_q, ex_hit_d;
  logic                  id_pred_q, id_pred_d, ex_pred_q, ex_pred_d;
  logic [DATA_WIDTH-1:0] id_target_q, id_target_d, ex_target_q, ex_target_d;

  logic                  upd_pred_q, upd_pred_d, upd_btb_q, upd_btb_d;
  logic                  act_taken_q, act_taken_d;
  logic [DATA_WIDTH-1:0] res_pc_q, res_pc_d, res_tgt_q, res_tgt_d;
  logic [CNT_WIDTH-1:0]  br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  logic resolve, taken, ptaken, tgt_diff, mispredict;

  always_comb begin
    resolve    = ex_valid_q & (ex_is_branch | ex_is_jump) & ~stall;
    taken      = ex_is_jump | ex_taken;
    ptaken     = ex_hit_q & (ex_pred_q | ex_is_jump);
    tgt_diff   = (ex_target_q != ex_target);
    mispredict = resolve & ((ptaken != taken) | (taken & ptaken & tgt_diff));

    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_hit_d    = id_hit_q;
    id_pred_d   = id_pred_q;
    id_target_d = id_target_q;
    ex_valid_d  = ex_valid_q;
    ex_pc_d     = ex_pc_q;
    ex_hit_d    = ex_hit_q;
    ex_pred_d   = ex_pred_q;
    ex_target_d = ex_target_q;

    // A redirect kills both tracked instructions and drops this cycle's fetch.
    if (mispredict) begin
      id_valid_d  = 1'b0;
      id_pc_d     = '0;
      id_hit_d    = 1'b0;
      id_pred_d   = 1'b0;
      id_target_d = '0;
      ex_valid_d  = 1'b0;
      ex_pc_d     = '0;
      ex_hit_d    = 1'b0;
      ex_pred_d   = 1'b0;
      ex_target_d = '0;
    end else if (!stall) begin
      ex_valid_d  = id_valid_q;
      ex_pc_d     = id_pc_q;
      ex_hit_d    = id_hit_q;
      ex_pred_d   = id_pred_q;
      ex_target_d = id_target_q;
      id_valid_d  = if_valid;
      id_pc_d     = if_pc;
      id_hit_d    = if_hit;
      id_pred_d   = if_pred;
      id_target_d = if_target;
    end

    // Branch+jump together behaves as a jump, so the direction predictor is left alone.
    upd_pred_d  = resolve & ex_is_branch & ~ex_is_jump;
    upd_btb_d   = resolve & taken & (~ex_hit_q | tgt_diff);
    act_taken_d = resolve ? taken : act_taken_q;
    res_pc_d    = resolve ? ex_pc_q : res_pc_q;
    res_tgt_d   = resolve ? ex_target : res_tgt_q;

    br_cnt_d = (resolve && (br_cnt_q != '1)) ? br_cnt_q + CNT_WIDTH'(1) : br_cnt_q;
    mp_cnt_d = (mispredict && (mp_cnt_q != '1)) ? mp_cnt_q + CNT_WIDTH'(1) : mp_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_hit_q    <= 1'b0;
      id_pred_q   <= 1'b0;
      id_target_q <= '0;
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_hit_q    <= 1'b0;
      ex_pred_q   <= 1'b0;
      ex_target_q <= '0;
      upd_pred_q  <= 1'b0;
      upd_btb_q   <= 1'b0;
      act_taken_q <= 1'b0;
      res_pc_q    <= '0;
      res_tgt_q   <= '0;
      br_cnt_q    <= '0;
      mp_cnt_q    <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_hit_q    <= id_hit_d;
      id_pred_q   <= id_pred_d;
      id_target_q <= id_target_d;
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_hit_q    <= ex_hit_d;
      ex_pred_q   <= ex_pred_d;
      ex_target_q <= ex_target_d;
      upd_pred_q  <= upd_pred_d;
      upd_btb_q   <= upd_btb_d;
      act_taken_q <= act_taken_d;
      res_pc_q    <= res_pc_d;
      res_tgt_q   <= res_tgt_d;
      br_cnt_q    <= br_cnt_d;
      mp_cnt_q    <= mp_cnt_d;
    end
  end

  assign redirect           = mispredict;
  assign flush              = mispredict;
  assign redirect_pc        = mispredict ? (taken ? ex_target : ex_pc_q + DATA_WIDTH'(4)) : '0;
  assign update_predictor   = upd_pred_q;
  assign update_btb         = upd_btb_q;
  assign actually_taken     = act_taken_q;
  assign resolved_pc        = res_pc_q;
  assign resolved_pc_target = res_tgt_q;
  assign br_count           = br_cnt_q;
  assign mispred_count      = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scenarios followed by random traffic, checked every cycle against a
// two-entry pipeline model built from the resolution rules.
module tb_branch_resolve_unit;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn, if_valid, if_hit, if_pred, stall;
  logic          ex_is_branch, ex_is_jump, ex_taken;
  logic [DW-1:0] if_pc, if_target, ex_target;
  logic          redirect, flush, update_predictor, update_btb, actually_taken;
  logic [DW-1:0] redirect_pc, resolved_pc, resolved_pc_target;
  logic [CW-1:0] br_count, mispred_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_pc(if_pc), .if_hit(if_hit),
    .if_pred(if_pred), .if_target(if_target), .stall(stall),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken),
    .ex_target(ex_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .update_predictor(update_predictor), .update_btb(update_btb),
    .actually_taken(actually_taken), .resolved_pc(resolved_pc),
    .resolved_pc_target(resolved_pc_target), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  typedef struct packed {
    logic          v;
    logic [DW-1:0] pc;
    logic          hit;
    logic          pred;
    logic [DW-1:0] tgt;
  } slot_t;

  int total = 0;
  int bad   = 0;

  // stimulus for the next cycle
  logic          s_rst, s_stall, s_iv, s_ih, s_ip, s_eb, s_ej, s_et;
  logic [DW-1:0] s_pc, s_itg, s_etg;

  // reference state
  slot_t         id_m, ex_m;
  logic          e_up, e_ub, e_at;
  logic [DW-1:0] e_rpc, e_rtgt;
  int            e_br, e_mp;

  logic          o_redirect;
  logic [DW-1:0] o_rpc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic quiet();
    s_rst = 0; s_stall = 0; s_iv = 0; s_ih = 0; s_ip = 0;
    s_eb = 0; s_ej = 0; s_et = 0; s_pc = '0; s_itg = '0; s_etg = '0;
  endtask

  task automatic fetch(input logic [DW-1:0] pc, input logic hit, input logic pred,
                       input logic [DW-1:0] tgt);
    s_iv = 1; s_pc = pc; s_ih = hit; s_ip = pred; s_itg = tgt;
  endtask

  task automatic tick();
    logic          res, tk, pt, mp;
    logic [DW-1:0] nxt;
    @(negedge clk);
    rstn = s_rst; stall = s_stall; if_valid = s_iv; if_pc = s_pc; if_hit = s_ih;
    if_pred = s_ip; if_target = s_itg; ex_is_branch = s_eb; ex_is_jump = s_ej;
    ex_taken = s_et; ex_target = s_etg;
    #1;
    res = ex_m.v && (s_eb || s_ej) && !s_stall;
    tk  = s_ej || s_et;
    pt  = ex_m.hit && (ex_m.pred || s_ej);
    mp  = res && ((pt != tk) || (tk && pt && ex_m.tgt != s_etg));
    nxt = tk ? s_etg : ex_m.pc + 32'd4;
    o_redirect = redirect;
    o_rpc      = redirect_pc;
    chk("redirect", 64'(redirect), 64'(mp));
    chk("flush", 64'(flush), 64'(mp));
    chk("redirect_pc", 64'(redirect_pc), mp ? 64'(nxt) : 64'd0);
    @(posedge clk);
    if (s_rst) begin
      id_m = '0; ex_m = '0; e_up = 0; e_ub = 0; e_at = 0;
      e_rpc = '0; e_rtgt = '0; e_br = 0; e_mp = 0;
    end else begin
      e_up = res && s_eb && !s_ej;
      e_ub = res && tk && (!ex_m.hit || ex_m.tgt != s_etg);
      if (res) begin
        e_at = tk; e_rpc = ex_m.pc; e_rtgt = s_etg;
        if (e_br < CMAX) e_br++;
      end
      if (mp && e_mp < CMAX) e_mp++;
      if (mp) begin
        id_m.v = 0; ex_m.v = 0;
      end else if (!s_stall) begin
        ex_m = id_m;
        id_m = '{v: s_iv, pc: s_pc, hit: s_ih, pred: s_ip, tgt: s_itg};
      end
    end
    #1;
    chk("update_predictor", 64'(update_predictor), 64'(e_up));
    chk("update_btb", 64'(update_btb), 64'(e_ub));
    chk("actually_taken", 64'(actually_taken), 64'(e_at));
    chk("resolved_pc", 64'(resolved_pc), 64'(e_rpc));
    chk("resolved_pc_target", 64'(resolved_pc_target), 64'(e_rtgt));
    chk("br_count", 64'(br_count), 64'(e_br));
    chk("mispred_count", 64'(mispred_count), 64'(e_mp));
  endtask

  task automatic do_reset();
    quiet(); s_rst = 1; fetch(32'h500, 1, 1, 32'h600);
    tick(); tick();
    quiet();
  endtask

  initial begin
    id_m = '0; ex_m = '0; e_up = 0; e_ub = 0; e_at = 0;
    e_rpc = '0; e_rtgt = '0; e_br = 0; e_mp = 0;
    quiet();
    rstn = 1; stall = 0; if_valid = 0; if_pc = '0; if_hit = 0; if_pred = 0;
    if_target = '0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0; ex_target = '0;

    // reset with fetch active, then plain NOPs
    do_reset();
    chk("rst_br_count", 64'(br_count), 64'd0);
    chk("rst_upd", 64'(update_predictor | update_btb | actually_taken), 64'd0);
    for (int i = 0; i < 3; i++) begin
      fetch(32'(i * 4), 0, 0, 32'h0); tick();
      chk("nop_redirect", 64'(o_redirect), 64'd0);
    end
    quiet(); tick(); tick();

    // correctly predicted taken branch
    do_reset();
    fetch(32'h100, 1, 1, 32'h200); tick();
    quiet(); tick();
    s_eb = 1; s_et = 1; s_etg = 32'h200; tick();
    chk("ok_redirect", 64'(o_redirect), 64'd0);
    chk("ok_upd_pred", 64'(update_predictor), 64'd1);
    chk("ok_res_pc", 64'(resolved_pc), 64'h100);
    quiet();

    // predicted taken, resolved not taken
    fetch(32'h40, 1, 1, 32'h80); tick();
    quiet(); tick();
    s_eb = 1; s_et = 0; s_etg = 32'h80; tick();
    chk("nt_redirect", 64'(o_redirect), 64'd1);
    chk("nt_rpc", 64'(o_rpc), 64'h44);
    chk("nt_mispred", 64'(mispred_count), 64'd1);
    quiet();

    // jump missing in BTB
    fetch(32'h10, 0, 0, 32'h0); tick();
    quiet(); tick();
    s_ej = 1; s_etg = 32'h300; tick();
    chk("jmp_rpc", 64'(o_rpc), 64'h300);
    chk("jmp_upd_btb", 64'(update_btb), 64'd1);
    chk("jmp_res_tgt", 64'(resolved_pc_target), 64'h300);
    quiet();

    // mispredicting branch held in EX by a stall
    fetch(32'h60, 1, 1, 32'h90); tick();
    quiet(); tick();
    s_eb = 1; s_et = 0; s_etg = 32'h90; s_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_redirect", 64'(o_redirect), 64'd0);
    end
    s_stall = 0; tick();
    chk("unstall_redirect", 64'(o_redirect), 64'd1);
    chk("unstall_upd", 64'(update_predictor), 64'd1);
    quiet(); tick();
    chk("single_upd", 64'(update_predictor), 64'd0);

    // not-taken fall-through wraps past the top of the address space
    fetch(32'hFFFF_FFFC, 1, 1, 32'h8); tick();
    quiet(); tick();
    s_eb = 1; s_et = 0; s_etg = 32'h8; tick();
    chk("wrap_redirect", 64'(o_redirect), 64'd1);
    chk("wrap_rpc", 64'(o_rpc), 64'h0);
    quiet();

    // drive the mispredict counter into saturation
    for (int i = 0; i < CMAX + 3; i++) begin
      fetch(32'h700, 0, 0, 32'h0); tick();
      quiet(); tick();
      s_ej = 1; s_etg = 32'h740; tick();
      quiet();
    end
    chk("sat_mispred", 64'(mispred_count), 64'(CMAX));
    chk("sat_br", 64'(br_count), 64'(CMAX));

    // random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [DW-1:0] pool_t;
      int kind;
      s_rst   = ($urandom_range(0, 299) == 0);
      s_stall = ($urandom_range(0, 4) == 0);
      s_iv    = ($urandom_range(0, 3) != 0);
      s_pc    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      s_ih    = 1'($urandom());
      s_ip    = 1'($urandom());
      s_itg   = 32'($urandom_range(0, 7)) << 4;
      kind    = $urandom_range(0, 5);
      s_eb    = (kind == 1 || kind == 2 || kind == 4);
      s_ej    = (kind == 3 || kind == 4);
      s_et    = 1'($urandom());
      pool_t  = 32'($urandom_range(0, 7)) << 4;
      s_etg   = ($urandom_range(0, 1) == 0) ? ex_m.tgt : pool_t;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
